// File: rtl/score_keeper_if.sv
// score_keeper_if -- game event inputs and display outputs of score_keeper.
//   goodColl       : pulse, food eaten (+1 point)
//   badColl        : pulse, fatal collision (game over)
//   start          : pulse, begin a new game
//   dispScore      : score to display
//   dispBlank      : 1 = display blanked (flash off phase)
//   isGameComplete : 1 while the game is over
//   newHigh        : 1 when the finished game set a new high score
// master = game/stimulus side, slave = score_keeper.
interface score_keeper_if #(
   parameter int SCORE_W = 7
);
   logic               goodColl;
   logic               badColl;
   logic               start;
   logic [SCORE_W-1:0] dispScore;
   logic               dispBlank;
   logic               isGameComplete;
   logic               newHigh;

   modport master (
      output goodColl, badColl, start,
      input  dispScore, dispBlank, isGameComplete, newHigh
   );

   modport slave (
      input  goodColl, badColl, start,
      output dispScore, dispBlank, isGameComplete, newHigh
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper -- tracks current, final and high score of a game and drives
// a score display. While the game is over the final score blinks for
// HOLD_CYCLES cycles, then the high score is shown steadily.
//   clk  : system clock, rising edge
//   nRst : asynchronous active-low reset
//   bus  : score_keeper_if.slave (collision/start pulses in, display out)
// All outputs are registered from next-state values, so they reflect an
// event in the cycle right after the edge that sampled it.
module score_keeper #(
   parameter int SCORE_W     = 7,
   parameter int MAX_SCORE   = 50,
   parameter int HOLD_CYCLES = 100,
   parameter int FLASH_HALF  = 10
) (
   input  logic             clk,
   input  logic             nRst,
   score_keeper_if.slave    bus
);
   // Keep counters at least one bit wide when a parameter is 1.
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int FW = (FLASH_HALF  > 1) ? $clog2(FLASH_HALF)  : 1;

   typedef enum logic [1:0] {PLAY, HOLD, SHOW_HIGH} state_t;

   state_t             r_state, w_state;
   logic [SCORE_W-1:0] r_curr, w_curr;
   logic [SCORE_W-1:0] r_high, w_high;
   logic [SCORE_W-1:0] r_final, w_final;
   logic [SCORE_W-1:0] w_inc;
   logic               r_gameHigh, w_gameHigh;
   logic [HW-1:0]      r_hold, w_hold;
   logic [FW-1:0]      r_flash, w_flash;
   logic               r_phase, w_phase;   // 1 = blank half of the blink

   logic [SCORE_W-1:0] r_dispScore, w_dispScore;
   logic               r_dispBlank, w_dispBlank;
   logic               r_complete,  w_complete;
   logic               r_newHigh,   w_newHigh;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state     <= PLAY;
         r_curr      <= '0;
         r_high      <= '0;
         r_final     <= '0;
         r_gameHigh  <= 1'b0;
         r_hold      <= '0;
         r_flash     <= '0;
         r_phase     <= 1'b0;
         r_dispScore <= '0;
         r_dispBlank <= 1'b0;
         r_complete  <= 1'b0;
         r_newHigh   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_curr      <= w_curr;
         r_high      <= w_high;
         r_final     <= w_final;
         r_gameHigh  <= w_gameHigh;
         r_hold      <= w_hold;
         r_flash     <= w_flash;
         r_phase     <= w_phase;
         r_dispScore <= w_dispScore;
         r_dispBlank <= w_dispBlank;
         r_complete  <= w_complete;
         r_newHigh   <= w_newHigh;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_curr     = r_curr;
      w_high     = r_high;
      w_final    = r_final;
      w_gameHigh = r_gameHigh;
      w_hold     = r_hold;
      w_flash    = r_flash;
      w_phase    = r_phase;
      // r_curr < MAX_SCORE <= 2**SCORE_W-1 in PLAY, so this cannot overflow.
      w_inc      = r_curr + SCORE_W'(1);

      case (r_state)
         PLAY: begin
            // Priority: start > badColl > goodColl.
            if (bus.start) begin
               w_curr     = '0;
               w_gameHigh = 1'b0;
            end else if (bus.badColl) begin
               w_state = HOLD;
               w_final = r_curr;
               w_hold  = '0;
               w_flash = '0;
               w_phase = 1'b0;
            end else if (bus.goodColl) begin
               w_curr = w_inc;
               if (w_inc > r_high) begin
                  w_high     = w_inc;
                  w_gameHigh = 1'b1;
               end
               if (w_inc == SCORE_W'(MAX_SCORE)) begin
                  w_state = HOLD;
                  w_final = w_inc;
                  w_hold  = '0;
                  w_flash = '0;
                  w_phase = 1'b0;
               end
            end
         end
         HOLD, SHOW_HIGH: begin
            if (bus.start) begin
               w_state    = PLAY;
               w_curr     = '0;
               w_gameHigh = 1'b0;
               w_hold     = '0;
               w_flash    = '0;
               w_phase    = 1'b0;
            end else if (r_state == HOLD) begin
               if (r_hold == HW'(HOLD_CYCLES - 1)) begin
                  w_state = SHOW_HIGH;
               end else begin
                  w_hold = r_hold + HW'(1);
                  if (r_flash == FW'(FLASH_HALF - 1)) begin
                     w_flash = '0;
                     w_phase = ~r_phase;
                  end else begin
                     w_flash = r_flash + FW'(1);
                  end
               end
            end
         end
         default: w_state = PLAY;
      endcase

      // Display follows the state being entered at this edge.
      w_complete  = (w_state != PLAY);
      w_newHigh   = w_complete & w_gameHigh;
      w_dispBlank = (w_state == HOLD) & w_phase;
      case (w_state)
         HOLD:      w_dispScore = w_final;
         SHOW_HIGH: w_dispScore = w_high;
         default:   w_dispScore = w_curr;
      endcase
   end

   assign bus.dispScore      = r_dispScore;
   assign bus.dispBlank      = r_dispBlank;
   assign bus.isGameComplete = r_complete;
   assign bus.newHigh        = r_newHigh;
endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: the stimulus pushes the display state
// expected after each clock edge; a monitor pops one entry per edge and
// compares. Async reset is checked directly, away from any edge.
module tb_score_keeper;
   logic clk  = 1'b0;
   logic nRst = 1'b1;

   score_keeper_if #(.SCORE_W(7)) sk_if ();

   score_keeper #(
      .SCORE_W(7), .MAX_SCORE(50), .HOLD_CYCLES(100), .FLASH_HALF(10)
   ) dut (
      .clk (clk),
      .nRst(nRst),
      .bus (sk_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    score;
      logic  blank;
      logic  comp;
      logic  nh;
      string tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input int sc, input logic bl, input logic c,
                               input logic nh, input string t);
      exp_t e;
      e.score = sc; e.blank = bl; e.comp = c; e.nh = nh; e.tag = t;
      return e;
   endfunction

   // Blank during HOLD cycles 10-19, 30-39, ...
   function automatic logic blink(input int k);
      return (k >= 10) && (((k / 10) % 2) == 1);
   endfunction

   // Drive one cycle of inputs and queue the state expected after the edge.
   task automatic cyc(input logic g, input logic b, input logic s, input exp_t e);
      @(negedge clk);
      sk_if.goodColl = g;
      sk_if.badColl  = b;
      sk_if.start    = s;
      q.push_back(e);
   endtask

   task automatic hold_run(input string t, input int sc, input logic nh,
                           input int k0, input int k1);
      for (int k = k0; k <= k1; k++)
         cyc(0, 0, 0, mk(sc, blink(k), 1'b1, nh, $sformatf("%s_k%0d", t, k)));
   endtask

   task automatic high_run(input string t, input int sc, input logic nh, input int n);
      for (int i = 0; i < n; i++)
         cyc(0, 0, 0, mk(sc, 1'b0, 1'b1, nh, $sformatf("%s_%0d", t, i)));
   endtask

   task automatic rst_check(input string t);
      chk({t, ".score"}, int'(sk_if.dispScore), 0);
      chk({t, ".blank"}, int'(sk_if.dispBlank), 0);
      chk({t, ".comp"},  int'(sk_if.isGameComplete), 0);
      chk({t, ".nh"},    int'(sk_if.newHigh), 0);
   endtask

   // Assert reset between edges, check outputs at once, release on negedge.
   task automatic async_reset(input string t);
      @(posedge clk);
      #3;
      sk_if.goodColl = 0; sk_if.badColl = 0; sk_if.start = 0;
      nRst = 1'b0;
      #1;
      rst_check(t);
      @(negedge clk);
      nRst = 1'b1;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".score"}, int'(sk_if.dispScore),      e.score);
            chk({e.tag, ".blank"}, int'(sk_if.dispBlank),      int'(e.blank));
            chk({e.tag, ".comp"},  int'(sk_if.isGameComplete), int'(e.comp));
            chk({e.tag, ".nh"},    int'(sk_if.newHigh),        int'(e.nh));
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue %0d", q.size());
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      int n;
      sk_if.goodColl = 0; sk_if.badColl = 0; sk_if.start = 0;
      #1 nRst = 1'b0;
      #2 rst_check("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) nRst = 1'b1;

      // Game 1: three points then crash; new high of 3.
      cyc(1, 0, 0, mk(1, 0, 0, 0, "g1_p1"));
      cyc(1, 0, 0, mk(2, 0, 0, 0, "g1_p2"));
      cyc(1, 0, 0, mk(3, 0, 0, 0, "g1_p3"));
      cyc(0, 1, 0, mk(3, 0, 1, 1, "g1_hold_k0"));
      hold_run("g1_hold", 3, 1, 1, 99);
      high_run("g1_high", 3, 1, 3);

      // Game 2: two points, no new high; high of 3 shown afterwards.
      cyc(0, 0, 1, mk(0, 0, 0, 0, "g2_start"));
      cyc(1, 0, 0, mk(1, 0, 0, 0, "g2_p1"));
      cyc(1, 0, 0, mk(2, 0, 0, 0, "g2_p2"));
      cyc(0, 1, 0, mk(2, 0, 1, 0, "g2_hold_k0"));
      hold_run("g2_hold", 2, 0, 1, 99);
      high_run("g2_high", 3, 0, 3);

      // Game 3: score 4, simultaneous good+bad keeps 4; start at HOLD cycle 40.
      cyc(0, 0, 1, mk(0, 0, 0, 0, "g3_start"));
      for (int i = 1; i <= 4; i++)
         cyc(1, 0, 0, mk(i, 0, 0, 0, $sformatf("g3_p%0d", i)));
      cyc(1, 1, 0, mk(4, 0, 1, 1, "g3_both_k0"));
      hold_run("g3_hold", 4, 1, 1, 40);
      cyc(0, 0, 1, mk(0, 0, 0, 0, "g3_restart"));

      // Game 4: reach MAX_SCORE; later collisions ignored; high 50.
      for (int i = 1; i <= 49; i++)
         cyc(1, 0, 0, mk(i, 0, 0, 0, $sformatf("g4_p%0d", i)));
      cyc(1, 0, 0, mk(50, 0, 1, 1, "g4_max_k0"));
      cyc(1, 0, 0, mk(50, 0, 1, 1, "g4_goodign_k1"));
      cyc(0, 1, 0, mk(50, 0, 1, 1, "g4_badign_k2"));
      hold_run("g4_hold", 50, 1, 3, 99);
      high_run("g4_high", 50, 1, 2);

      // Reset clears high score; game to 7, then reset in SHOW_HIGH.
      async_reset("rst_mid");
      for (int i = 1; i <= 7; i++)
         cyc(1, 0, 0, mk(i, 0, 0, 0, $sformatf("g5_p%0d", i)));
      cyc(0, 1, 0, mk(7, 0, 1, 1, "g5_hold_k0"));
      hold_run("g5_hold", 7, 1, 1, 99);
      high_run("g5_high", 7, 1, 2);
      async_reset("rst_showhigh");
      cyc(0, 1, 0, mk(0, 0, 1, 0, "g6_hold_k0"));
      hold_run("g6_hold", 0, 0, 1, 99);
      high_run("g6_high", 0, 0, 2);
      cyc(0, 0, 0, mk(0, 0, 1, 0, "g6_idle"));

      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending entries expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter SCORE_W, default 7, width of all score values.
REQ-002 Parameter MAX_SCORE, default 50, winning score; SHALL satisfy 1 <= MAX_SCORE <= 2**SCORE_W-1.
REQ-003 Parameter HOLD_CYCLES, default 100, number of cycles the final score is shown before the high score is shown; SHALL be >= 1.
REQ-004 Parameter FLASH_HALF, default 10, blink half-period in cycles; SHALL be >= 1.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 nRst  in  1  asynchronous active-low reset.
REQ-007 goodColl  in  1  one-cycle pulse: food eaten, +1 point.
REQ-008 badColl  in  1  one-cycle pulse: fatal collision, game over.
REQ-009 start  in  1  one-cycle pulse: begin a new game.
REQ-010 dispScore  out  SCORE_W  score to display.
REQ-011 dispBlank  out  1  1 = display blanked (flash off phase).
REQ-012 isGameComplete  out  1  1 while the game is over (HOLD or SHOW_HIGH).
REQ-013 newHigh  out  1  1 when the game just ended set a new high score.

Function
REQ-014 The block SHALL implement FSM states PLAY, HOLD, SHOW_HIGH; all outputs SHALL be registered.
REQ-015 PLAY behaviour:
- goodColl SHALL set currScore to currScore+1 at that edge.
- dispScore SHALL equal the new value in the following cycle.
- If the new currScore exceeds highScore, highScore SHALL take the new value at the same edge and the game-high flag SHALL be set.
REQ-016 PLAY, badColl: the FSM SHALL go to HOLD and latch finalScore = currScore, not incremented; badColl SHALL win over a same-cycle goodColl.
REQ-017 PLAY, goodColl with currScore+1 == MAX_SCORE: currScore, finalScore and highScore update as in REQ-015, and the FSM SHALL go to HOLD at the same edge; currScore SHALL never exceed MAX_SCORE.
REQ-018 PLAY, start: currScore SHALL clear to 0 and the game-high flag SHALL clear; the FSM SHALL stay in PLAY; start SHALL win over same-cycle collisions.
REQ-019 HOLD behaviour:
- dispScore SHALL equal finalScore.
- A hold counter SHALL run from 0 to HOLD_CYCLES-1 and then move the FSM to SHOW_HIGH.
- dispBlank SHALL be 0 for the first FLASH_HALF cycles, then toggle every FLASH_HALF cycles.
REQ-020 SHOW_HIGH: dispScore SHALL equal highScore and dispBlank SHALL be 0.
REQ-021 In HOLD and SHOW_HIGH:
- goodColl and badColl SHALL be ignored.
- start SHALL move the FSM to PLAY with currScore 0 and hold/flash counters cleared.
- Outputs SHALL show the PLAY state in the next cycle.
REQ-022 isGameComplete SHALL be 1 exactly while the FSM is in HOLD or SHOW_HIGH.
REQ-023 newHigh SHALL equal the game-high flag while isGameComplete=1, and SHALL be 0 in PLAY.
REQ-024 highScore SHALL persist across games; only nRst SHALL clear it.
REQ-025 Counter widths SHALL be sized by ceiling log2 of HOLD_CYCLES and FLASH_HALF, with no wrap before terminal count.

Reset
REQ-026 On nRst=0, asynchronously:
- FSM = PLAY; currScore, highScore and finalScore = 0; counters and game-high flag = 0.
- dispScore = 0, dispBlank = 0, isGameComplete = 0, newHigh = 0.
REQ-027 Reset asserted mid-HOLD or mid-SHOW_HIGH SHALL abort immediately to the REQ-026 values, including highScore = 0.

Verification
REQ-028 Reset, 3 goodColl pulses, badColl -> dispScore 1,2,3; isGameComplete=1; dispScore=3 blinking for 100 cycles with blank on cycles 10-19, 30-39, ...; newHigh=1; then dispScore=3 steady.
REQ-029 Second game after start: 2 goodColl, badColl -> HOLD shows 2 with newHigh=0; SHOW_HIGH shows 3.
REQ-030 50 goodColl pulses -> HOLD entered on the 50th edge; dispScore=50; extra goodColl ignored; highScore=50.
REQ-031 goodColl and badColl in the same cycle with currScore=4 -> finalScore=4, HOLD entered.
REQ-032 start pulse at HOLD cycle 40 -> PLAY next cycle, dispScore=0, dispBlank=0, isGameComplete=0.
REQ-033 nRst asserted in SHOW_HIGH with highScore=7 -> all outputs 0 asynchronously; the next badColl shows finalScore 0 and highScore 0.
